// File: rtl/comparator_4bit.sv
// Registered magnitude comparator: one-hot equal/greater/lesser flags plus max/min
// operand select, one cycle after an in_valid sample, unsigned or two's-complement.
module comparator_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             equal,
  output logic             greater,
  output logic             lesser,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out
);

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

  logic             out_valid_q, out_valid_d;
  logic             equal_q,     equal_d;
  logic             greater_q,   greater_d;
  logic             lesser_q,    lesser_d;
  logic [WIDTH-1:0] max_q,       max_d;
  logic [WIDTH-1:0] min_q,       min_d;

  logic [WIDTH-1:0] key_a_c, key_b_c;
  logic             eq_c, gt_c;

  always_comb begin
    key_a_c = a ^ (signed_mode ? SIGN_MASK : '0);
    key_b_c = b ^ (signed_mode ? SIGN_MASK : '0);
    eq_c    = (a == b);
    gt_c    = (key_a_c > key_b_c);
  end

  // Result registers hold their last value whenever no sample is taken.
  always_comb begin
    out_valid_d = in_valid;
    equal_d     = equal_q;
    greater_d   = greater_q;
    lesser_d    = lesser_q;
    max_d       = max_q;
    min_d       = min_q;
    if (in_valid) begin
      equal_d   = eq_c;
      greater_d = gt_c;
      lesser_d  = !eq_c && !gt_c;
      max_d     = (gt_c || eq_c) ? a : b;
      min_d     = (gt_c || eq_c) ? b : a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      equal_q     <= 1'b0;
      greater_q   <= 1'b0;
      lesser_q    <= 1'b0;
      max_q       <= '0;
      min_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      equal_q     <= equal_d;
      greater_q   <= greater_d;
      lesser_q    <= lesser_d;
      max_q       <= max_d;
      min_q       <= min_d;
    end
  end

  assign out_valid = out_valid_q;
  assign equal     = equal_q;
  assign greater   = greater_q;
  assign lesser    = lesser_q;
  assign max_out   = max_q;
  assign min_out   = min_q;

endmodule

// File: tb/tb_comparator_4bit.sv
// Bench for comparator_4bit: vector table plus exhaustive/random sweeps through a
// scoreboard queue, with hand-written hold, reset and back-to-back sequences.
module tb_comparator_4bit;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sm;
    logic       eq;
    logic       gt;
    logic       lt;
    logic [3:0] mx;
    logic [3:0] mn;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       signed_mode;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       equal;
  logic       greater;
  logic       lesser;
  logic [3:0] max_out;
  logic [3:0] min_out;

  int n_checks;
  int n_fail;
  vec_t sb_q[$];

  comparator_4bit #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .equal      (equal),
    .greater    (greater),
    .lesser     (lesser),
    .max_out    (max_out),
    .min_out    (min_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t model(input logic [3:0] va, input logic [3:0] vb, input logic vsm);
    vec_t r;
    r.a  = va;
    r.b  = vb;
    r.sm = vsm;
    r.eq = (va == vb);
    r.gt = vsm ? ($signed(va) > $signed(vb)) : (va > vb);
    r.lt = vsm ? ($signed(va) < $signed(vb)) : (va < vb);
    r.mx = r.lt ? vb : va;
    r.mn = r.lt ? va : vb;
    return r;
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic ov, input logic eq, input logic gt,
                         input logic lt, input logic [3:0] mx, input logic [3:0] mn);
    n_checks++;
    if (out_valid !== ov || equal !== eq || greater !== gt || lesser !== lt ||
        max_out !== mx || min_out !== mn) begin
      n_fail++;
      $display("FAIL %s: got v=%b e=%b g=%b l=%b max=%0d min=%0d, required v=%b e=%b g=%b l=%b max=%0d min=%0d",
               name, out_valid, equal, greater, lesser, max_out, min_out, ov, eq, gt, lt, mx, mn);
    end
  endtask

  // Scoreboard: every fresh result must match the oldest outstanding sample.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: got out_valid=1, required 0 (no sample outstanding)");
        end else begin
          e = sb_q.pop_front();
          if (equal !== e.eq || greater !== e.gt || lesser !== e.lt ||
              max_out !== e.mx || min_out !== e.mn) begin
            n_fail++;
            $display("FAIL result a=%0d b=%0d sm=%b: got e=%b g=%b l=%b max=%0d min=%0d, required e=%b g=%b l=%b max=%0d min=%0d",
                     e.a, e.b, e.sm, equal, greater, lesser, max_out, min_out,
                     e.eq, e.gt, e.lt, e.mx, e.mn);
          end
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    in_valid    = 1'b1;
    signed_mode = v.sm;
    a           = v.a;
    b           = v.b;
    sb_q.push_back(v);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    signed_mode = 1'($urandom_range(0, 1));
    a           = 4'($urandom_range(0, 15));
    b           = 4'($urandom_range(0, 15));
  endtask

  vec_t tbl[10];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tbl[0] = '{a:4'd5,  b:4'd3,  sm:1'b0, eq:1'b0, gt:1'b1, lt:1'b0, mx:4'd5,  mn:4'd3};
    tbl[1] = '{a:4'd3,  b:4'd3,  sm:1'b0, eq:1'b1, gt:1'b0, lt:1'b0, mx:4'd3,  mn:4'd3};
    tbl[2] = '{a:4'd0,  b:4'd0,  sm:1'b0, eq:1'b1, gt:1'b0, lt:1'b0, mx:4'd0,  mn:4'd0};
    tbl[3] = '{a:4'd15, b:4'd15, sm:1'b0, eq:1'b1, gt:1'b0, lt:1'b0, mx:4'd15, mn:4'd15};
    tbl[4] = '{a:4'd15, b:4'd1,  sm:1'b0, eq:1'b0, gt:1'b1, lt:1'b0, mx:4'd15, mn:4'd1};
    tbl[5] = '{a:4'd15, b:4'd1,  sm:1'b1, eq:1'b0, gt:1'b0, lt:1'b1, mx:4'd1,  mn:4'd15};
    tbl[6] = '{a:4'd8,  b:4'd7,  sm:1'b1, eq:1'b0, gt:1'b0, lt:1'b1, mx:4'd7,  mn:4'd8};
    tbl[7] = '{a:4'd8,  b:4'd7,  sm:1'b0, eq:1'b0, gt:1'b1, lt:1'b0, mx:4'd8,  mn:4'd7};
    tbl[8] = '{a:4'd7,  b:4'd8,  sm:1'b1, eq:1'b0, gt:1'b1, lt:1'b0, mx:4'd7,  mn:4'd8};
    tbl[9] = '{a:4'd15, b:4'd15, sm:1'b1, eq:1'b1, gt:1'b0, lt:1'b0, mx:4'd15, mn:4'd15};

    rst_n = 1'b0; in_valid = 1'b0; signed_mode = 1'b0; a = 4'd0; b = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    chk_all("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk_all("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    for (int i = 0; i < 10; i++) drive(tbl[i]);
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        drive(model(4'(ia), 4'(ib), 1'b0));
    for (int i = 0; i < 64; i++)
      drive(model(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))));
    idle();
    idle();
    @(negedge clk);
    chk_bit("sweep_drained", 1'(sb_q.size() == 0), 1'b1);

    // Back-to-back: lesser, equal, greater with out_valid held high.
    drive(model(4'd1, 4'd2, 1'b0));
    drive(model(4'd2, 4'd2, 1'b0));
    @(negedge clk);
    chk_all("b2b_0", 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1);
    drive(model(4'd3, 4'd2, 1'b0));
    @(negedge clk);
    chk_all("b2b_1", 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd2);
    idle();
    @(negedge clk);
    chk_all("b2b_2", 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 4'd2);
    idle();
    @(negedge clk);
    chk_bit("b2b_end_valid", out_valid, 1'b0);

    // Hold: result of (9,2) stays while in_valid is low and a/b wander.
    drive(model(4'd9, 4'd2, 1'b0));
    idle();
    @(negedge clk);
    chk_all("hold_fresh", 1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 4'd2);
    for (int i = 0; i < 3; i++) begin
      idle();
      @(negedge clk);
      chk_all($sformatf("hold_%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 4'd2);
    end

    // Reset between edges discards an in-flight sample and clears outputs at once.
    drive(model(4'd5, 4'd5, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("reset_async", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      idle();
      @(negedge clk);
      chk_all($sformatf("reset_release_%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    end

    drive(model(4'd14, 4'd6, 1'b1));
    idle();
    @(negedge clk);
    chk_all("after_reset_signed", 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 4'd14);
    idle();
    @(negedge clk);
    chk_bit("final_drained", 1'(sb_q.size() == 0), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
